// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic defaults and carry-select block geometry helpers
package arith_pkg;

    localparam int DEF_WIDTH = 13;
    localparam int DEF_LOW_W = 4;
    localparam int DEF_BLK_W = 4;

    function automatic int num_blks(input int width, input int low_w, input int blk_w);
        return (width - low_w + blk_w - 1) / blk_w;
    endfunction

    // The last upper block absorbs whatever bits remain after the full-width blocks.
    function automatic int blk_width(input int idx, input int width, input int low_w, input int blk_w);
        int rem;
        rem = width - low_w - idx * blk_w;
        return (rem < blk_w) ? rem : blk_w;
    endfunction

endpackage

// File: rtl/csel_block.sv
// rtl/csel_block.sv - carry-select block producing sums for both possible carry-ins
module csel_block #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum0,
    output logic         cout0,
    output logic [W-1:0] sum1,
    output logic         cout1
);

    logic [W:0] w_t0;
    logic [W:0] w_t1;

    assign w_t0 = {1'b0, x} + {1'b0, y};
    assign w_t1 = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, 1'b1};

    assign sum0  = w_t0[W-1:0];
    assign cout0 = w_t0[W];
    assign sum1  = w_t1[W-1:0];
    assign cout1 = w_t1[W];

endmodule

// File: rtl/csel_sub_pipe.sv
// rtl/csel_sub_pipe.sv - two-stage pipelined carry-select subtractor with valid/ready handshake
module csel_sub_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOW_W = DEF_LOW_W,
    parameter int BLK_W = DEF_BLK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             borrow,
    output logic             zero
);

    localparam int UP_W = WIDTH - LOW_W;
    localparam int NB   = num_blks(WIDTH, LOW_W, BLK_W);

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_nb;
    logic [LOW_W-1:0] w_lsum;
    logic             w_lcout;
    logic [UP_W-1:0]  w_s0;
    logic [UP_W-1:0]  w_s1;
    logic [NB-1:0]    w_c0;
    logic [NB-1:0]    w_c1;
    logic [UP_W-1:0]  w_up;
    logic             w_carry;
    logic [WIDTH:0]   w_diff;

    logic             r_s1_valid;
    logic [LOW_W-1:0] r_lsum;
    logic             r_lcout;
    logic [UP_W-1:0]  r_s0;
    logic [UP_W-1:0]  r_s1;
    logic [NB-1:0]    r_c0;
    logic [NB-1:0]    r_c1;
    logic             r_s2_valid;
    logic [WIDTH:0]   r_diff;
    logic             r_borrow;
    logic             r_zero;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign w_in_fire = in_valid && w_s1_adv;

    // Subtraction as a + ~b + 1: the +1 enters as the low block's carry-in.
    assign w_nb = ~b;

    always_comb begin
        logic c;
        c      = 1'b1;
        w_lsum = '0;
        for (int i = 0; i < LOW_W; i++) begin
            w_lsum[i] = a[i] ^ w_nb[i] ^ c;
            c         = (a[i] & w_nb[i]) | (c & (a[i] ^ w_nb[i]));
        end
        w_lcout = c;
    end

    for (genvar g = 0; g < NB; g++) begin : g_blk
        localparam int OFF = g * BLK_W;
        localparam int BW  = blk_width(g, WIDTH, LOW_W, BLK_W);
        csel_block #(.W(BW)) u_blk (
            .x     (a[LOW_W+OFF +: BW]),
            .y     (w_nb[LOW_W+OFF +: BW]),
            .sum0  (w_s0[OFF +: BW]),
            .cout0 (w_c0[g]),
            .sum1  (w_s1[OFF +: BW]),
            .cout1 (w_c1[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_lsum     <= '0;
            r_lcout    <= 1'b0;
            r_s0       <= '0;
            r_s1       <= '0;
            r_c0       <= '0;
            r_c1       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_lsum  <= w_lsum;
                r_lcout <= w_lcout;
                r_s0    <= w_s0;
                r_s1    <= w_s1;
                r_c0    <= w_c0;
                r_c1    <= w_c1;
            end
        end
    end

    // Resolve the carry chain block by block, picking each block's precomputed candidate.
    always_comb begin
        logic c;
        c    = r_lcout;
        w_up = '0;
        for (int g = 0; g < NB; g++) begin
            for (int j = 0; j < BLK_W; j++) begin
                int k;
                k = g * BLK_W + j;
                if (k < UP_W) begin
                    w_up[k] = c ? r_s1[k] : r_s0[k];
                end
            end
            c = c ? r_c1[g] : r_c0[g];
        end
        w_carry = c;
    end

    assign w_diff = {~w_carry, w_up, r_lsum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff   <= w_diff;
                r_borrow <= ~w_carry;
                r_zero   <= ~|w_diff;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_csel_sub_pipe.sv
// tb/tb_csel_sub_pipe.sv - self-checking bench with arithmetic reference model and scoreboard
module tb_csel_sub_pipe;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   diff;
    logic         borrow;
    logic         zero;

    int total = 0;
    int bad   = 0;

    logic [W+2:0] q[$];
    logic         hold_pend = 1'b0;
    logic [W:0]   hold_diff = '0;
    logic         last_fire = 1'b0;

    csel_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {zero, borrow, diff} from plain signed arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int         d;
        logic [W:0] dd;
        d  = int'(ma) - int'(mb);
        dd = d[W:0];
        return {(ma == mb), (ma < mb), dd};
    endfunction

    // One clock cycle: drive, settle, check outputs and scoreboard, then step past the edge.
    task automatic tick(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ordy);
        logic [W+2:0] e;
        in_valid  = v;
        a         = ta;
        b         = tb_v;
        out_ready = ordy;
        #2;
        if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_diff", diff, hold_diff);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("diff", diff, e[W:0]);
                chk("borrow", borrow, e[W+1]);
                chk("zero", zero, e[W+2]);
                chk("borrow_msb", borrow, diff[W]);
            end
        end
        hold_pend = out_valid && !out_ready;
        hold_diff = diff;
        last_fire = in_valid && in_ready;
        if (last_fire) q.push_back(model(ta, tb_v));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick(1'b0, '0, '0, 1'b1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ordy);
        int n;
        n = 0;
        do begin
            tick(1'b1, ta, tb_v, ordy);
            n++;
        end while (!last_fire && n < 50);
        chk("send_accepted", last_fire, 1);
    endtask

    logic [W-1:0] dir_a[6] = '{13'd0, 13'd4660, 13'd16, 13'd4096, 13'd8191, 13'd8191};
    logic [W-1:0] dir_b[6] = '{13'd8191, 13'd4660, 13'd1, 13'd1, 13'd0, 13'd8191};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_zero", zero, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: 100 - 37 appears exactly two cycles after transfer.
        tick(1'b1, 13'd100, 13'd37, 1'b1);
        chk("lat_c0_accept", last_fire, 1);
        in_valid = 1'b0;
        #2;
        chk("lat_c1_ov", out_valid, 0);
        @(posedge clk);
        #3;
        chk("lat_c2_ov", out_valid, 1);
        chk("lat_c2_diff", diff, 14'h003F);
        tick(1'b0, '0, '0, 1'b1);
        #2;
        chk("lat_c3_ov", out_valid, 0);
        @(posedge clk);
        #1;

        // Boundary pairs back-to-back.
        for (int i = 0; i < 6; i++) send(dir_a[i], dir_b[i], 1'b1);
        drain();

        // Five back-to-back with out_ready low on cycles 3..5.
        begin
            int cyc;
            int sent;
            logic saw_block;
            cyc       = 0;
            sent      = 0;
            saw_block = 1'b0;
            while (sent < 5 && cyc < 40) begin
                tick(1'b1, W'(1000 + sent * 111), W'(500 + sent * 333), !(cyc >= 3 && cyc <= 5));
                if (!last_fire) saw_block = 1'b1;
                if (last_fire) sent++;
                cyc++;
            end
            chk("stream_sent", sent, 5);
            chk("stream_in_ready_dropped", saw_block, 1);
            drain();
        end

        // Randomised traffic with random stalls.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 8191));
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom_range(0, 8191));
            if ($urandom_range(0, 15) == 0) ra = '0;
            if ($urandom_range(0, 15) == 0) rb = '1;
            tick($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with two transactions in flight discards both.
        send(13'd77, 13'd11, 1'b0);
        send(13'd5, 13'd900, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        hold_pend = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            chk("after_midrst_ov", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
